// File: rtl/pipe_pkg.sv
// Shared definitions for the handshake pipeline stages: default widths,
// the bubble control value and the common control-field layout.
package pipe_pkg;

  localparam int DATA_W_DEF = 96;
  localparam int CTRL_W_DEF = 7;
  localparam int CNT_W_DEF  = 16;

  // Control value carried by an empty slot (no writes, no memory access).
  localparam logic [CTRL_W_DEF-1:0] CTRL_BUBBLE = '0;

  // Bit offsets of the control fields inside ctrl, shared by every stage.
  localparam int CTRL_ALUOP_LSB = 0;
  localparam int CTRL_ALUOP_MSB = 1;
  localparam int CTRL_ALUSRC    = 2;
  localparam int CTRL_REGWRITE  = 3;
  localparam int CTRL_MEMWRITE  = 4;
  localparam int CTRL_MEMREAD   = 5;
  localparam int CTRL_MEMTOREG  = 6;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_RSVD  = 2'b11
  } aluop_e;

  // Packed view matching the offsets above (aluop in the low bits).
  typedef struct packed {
    logic   memtoreg;
    logic   memread;
    logic   memwrite;
    logic   regwrite;
    logic   alusrc;
    aluop_e aluop;
  } ctrl_t;

endpackage

// File: rtl/pipe_slot.sv
// One pipeline entry: valid flag, payload and control. A cleared slot keeps
// its payload but zeroes its control, and control reads as bubble when empty.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] load_data,
  input  logic [CTRL_W-1:0] load_ctrl,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [CTRL_W-1:0] ctrl
);

  logic              vld_p0;
  logic [DATA_W-1:0] data_p0;
  logic [CTRL_W-1:0] ctrl_p0;

  // Slot register: load wins over clear; clear never touches the payload.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0  <= 1'b0;
      data_p0 <= '0;
      ctrl_p0 <= CTRL_W'(CTRL_BUBBLE);
    end else if (load) begin
      vld_p0  <= 1'b1;
      data_p0 <= load_data;
      ctrl_p0 <= load_ctrl;
    end else if (clear) begin
      vld_p0  <= 1'b0;
      ctrl_p0 <= CTRL_W'(CTRL_BUBBLE);
    end
  end

  assign valid = vld_p0;
  assign data  = data_p0;
  assign ctrl  = vld_p0 ? ctrl_p0 : CTRL_W'(CTRL_BUBBLE);

endmodule

// File: rtl/pipe_stage_hs.sv
// Valid/ready pipeline register between core stages. SKID=1 adds a second
// slot so ready_o comes straight from a flop; SKID=0 is a single slot whose
// ready passes through from downstream. Also counts stalled output cycles.
module pipe_stage_hs
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int SKID   = 1,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DATA_W-1:0] data_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] data_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  logic              down_ok;
  logic              acc_in;
  logic              acc_out;
  logic              main_vld;
  logic              main_load;
  logic              main_clear;
  logic [DATA_W-1:0] main_src_data;
  logic [CTRL_W-1:0] main_src_ctrl;
  logic              skid_vld;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [CNT_W-1:0]  stall_cnt_p0;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign down_ok = ready_i & ~stall_i;
  assign acc_in  = start_i & valid_i & ready_o;
  assign acc_out = start_i & main_vld & down_ok;

  // The skid entry is always older than anything arriving, so it refills
  // main first. Flush suppresses every load, dropping a same-cycle arrival.
  assign main_src_data = skid_vld ? skid_data : data_i;
  assign main_src_ctrl = skid_vld ? skid_ctrl : ctrl_i;
  assign main_load     = ~flush_i & ((acc_in & (~main_vld | acc_out)) | (acc_out & skid_vld));
  assign main_clear    = flush_i | acc_out;

  pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
    .clk       (clk_i),
    .rst       (rst_i),
    .load      (main_load),
    .clear     (main_clear),
    .load_data (main_src_data),
    .load_ctrl (main_src_ctrl),
    .valid     (main_vld),
    .data      (data_o),
    .ctrl      (ctrl_o)
  );

  generate
    if (SKID != 0) begin : g_skid
      logic skid_load;
      logic skid_clear;

      // An arrival that main cannot take this edge parks in the skid slot.
      assign skid_load  = ~flush_i & acc_in & main_vld & ~acc_out;
      assign skid_clear = flush_i | acc_out;
      assign ready_o    = start_i & ~skid_vld;

      pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
        .clk       (clk_i),
        .rst       (rst_i),
        .load      (skid_load),
        .clear     (skid_clear),
        .load_data (data_i),
        .load_ctrl (ctrl_i),
        .valid     (skid_vld),
        .data      (skid_data),
        .ctrl      (skid_ctrl)
      );
    end else begin : g_noskid
      assign skid_vld  = 1'b0;
      assign skid_data = '0;
      assign skid_ctrl = '0;
      assign ready_o   = start_i & (~main_vld | down_ok);
    end
  endgenerate

  assign valid_o = main_vld;

  // Stall counter: cycles with a valid output held back, saturating.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_p0 <= '0;
    end else if (start_i & main_vld & ~down_ok) begin
      stall_cnt_p0 <= sat_inc(stall_cnt_p0);
    end
  end

  assign stall_cnt_o = stall_cnt_p0;

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Bench for pipe_stage_hs: a SKID=1 instance (16-bit counter) and a SKID=0
// instance (4-bit counter) share stimulus; a scoreboard follows the SKID=1 one.
module tb_pipe_stage_hs;
  localparam int DW = 96;
  localparam int CW = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b1;
  logic stall = 1'b0;
  logic flush = 1'b0;
  logic valid = 1'b0;
  logic ready = 1'b1;
  logic [DW-1:0] data = '0;
  logic [CW-1:0] ctrl = '0;

  logic s_ready, s_valid;
  logic [DW-1:0] s_data;
  logic [CW-1:0] s_ctrl;
  logic [15:0] s_cnt;
  logic p_ready, p_valid;
  logic [DW-1:0] p_data;
  logic [CW-1:0] p_ctrl;
  logic [3:0] p_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } beat_t;
  beat_t sb[$];
  beat_t mon_exp;

  always #5 clk = ~clk;

  pipe_stage_hs #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(16)) u_skid (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stall_i(stall), .flush_i(flush),
    .valid_i(valid), .ready_o(s_ready), .data_i(data), .ctrl_i(ctrl),
    .valid_o(s_valid), .ready_i(ready), .data_o(s_data), .ctrl_o(s_ctrl),
    .stall_cnt_o(s_cnt)
  );

  pipe_stage_hs #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .CNT_W(4)) u_pass (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stall_i(stall), .flush_i(flush),
    .valid_i(valid), .ready_o(p_ready), .data_i(data), .ctrl_i(ctrl),
    .valid_o(p_valid), .ready_i(ready), .data_o(p_data), .ctrl_o(p_ctrl),
    .stall_cnt_o(p_cnt)
  );

  function automatic logic [DW-1:0] mk_data(input int tag);
    return {32'(tag) ^ 32'hDEAD_BEEF, 32'(tag * 7 + 3), 32'(tag)};
  endfunction

  function automatic logic [CW-1:0] mk_ctrl(input int tag);
    return CW'(tag * 5 + 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input int tag);
    valid = v;
    data  = mk_data(tag);
    ctrl  = mk_ctrl(tag);
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b1; stall = 1'b0; flush = 1'b0; valid = 1'b0; ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Scoreboard monitor: decides the coming edge's transfers mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      if (!s_valid) begin
        n_cmp++;
        if (s_ctrl !== '0) begin n_bad++; $display("FAIL bubble_ctrl: ctrl_o=%h required 0", s_ctrl); end
      end
      if (start && s_valid && ready && !stall) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++; $display("FAIL sb_unexpected: data_o=%h taken with nothing expected", s_data);
        end else begin
          mon_exp = sb.pop_front();
          if ({s_data, s_ctrl} !== mon_exp) begin
            n_bad++; $display("FAIL sb_order: got data=%h ctrl=%h required data=%h ctrl=%h", s_data, s_ctrl, mon_exp.d, mon_exp.c);
          end
        end
      end
      if (flush) sb.delete();
      else if (start && valid && s_ready) sb.push_back({data, ctrl});
    end
  end

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; valid = 1'b1; ready = 1'b1; data = mk_data(99); ctrl = 7'h7F;
    tick();
    tick();
    n_cmp++; if (s_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b required 0", s_valid); end
    n_cmp++; if (s_ctrl !== '0) begin n_bad++; $display("FAIL rst_ctrl: got %h required 0", s_ctrl); end
    n_cmp++; if (s_data !== '0) begin n_bad++; $display("FAIL rst_data: got %h required 0", s_data); end
    n_cmp++; if (s_cnt !== '0) begin n_bad++; $display("FAIL rst_cnt: got %0d required 0", s_cnt); end
    n_cmp++; if (p_valid !== 1'b0 || p_ctrl !== '0 || p_data !== '0) begin n_bad++; $display("FAIL rst_noskid: valid=%b ctrl=%h data=%h required all 0", p_valid, p_ctrl, p_data); end
    rst = 1'b0; valid = 1'b0;
    #1;
    n_cmp++; if (s_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %b required 1", s_ready); end
    n_cmp++; if (p_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready_noskid: got %b required 1", p_ready); end
    start = 1'b0;
    #1;
    n_cmp++; if (s_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready_nostart: got %b required 0", s_ready); end
    start = 1'b1;
    tick();
  endtask

  task automatic test_stream();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, i);
      #1;
      n_cmp++; if (s_ready !== 1'b1) begin n_bad++; $display("FAIL stream_ready: beat %0d ready_o=%b required 1", i, s_ready); end
      tick();
      n_cmp++; if (s_valid !== 1'b1 || s_data !== mk_data(i)) begin n_bad++; $display("FAIL stream_out: beat %0d valid=%b data=%h required 1/%h", i, s_valid, s_data, mk_data(i)); end
      n_cmp++; if (p_valid !== 1'b1 || p_data !== mk_data(i)) begin n_bad++; $display("FAIL stream_out_noskid: beat %0d valid=%b data=%h required 1/%h", i, p_valid, p_data, mk_data(i)); end
    end
    valid = 1'b0;
    tick();
    n_cmp++; if (s_valid !== 1'b0 || s_ctrl !== '0) begin n_bad++; $display("FAIL stream_drain: valid=%b ctrl=%h required 0/0", s_valid, s_ctrl); end
  endtask

  task automatic test_skid_fill();
    do_reset();
    drive(1'b1, 20);
    tick();
    drive(1'b1, 21); stall = 1'b1;
    #1;
    n_cmp++; if (s_ready !== 1'b1) begin n_bad++; $display("FAIL skid_ready_first: got %b required 1", s_ready); end
    n_cmp++; if (p_ready !== 1'b0) begin n_bad++; $display("FAIL noskid_ready_stall: got %b required 0", p_ready); end
    tick();
    drive(1'b1, 22);
    #1;
    n_cmp++; if (s_ready !== 1'b0) begin n_bad++; $display("FAIL skid_ready_full: got %b required 0", s_ready); end
    tick();
    n_cmp++; if (s_ready !== 1'b0 || s_data !== mk_data(20)) begin n_bad++; $display("FAIL skid_hold: ready=%b data=%h required 0/%h", s_ready, s_data, mk_data(20)); end
    tick();
    stall = 1'b0;
    tick();
    n_cmp++; if (s_valid !== 1'b1 || s_data !== mk_data(21)) begin n_bad++; $display("FAIL skid_to_main: valid=%b data=%h required 1/%h", s_valid, s_data, mk_data(21)); end
    n_cmp++; if (s_ready !== 1'b1) begin n_bad++; $display("FAIL skid_ready_back: got %b required 1", s_ready); end
    tick();
    n_cmp++; if (s_data !== mk_data(22)) begin n_bad++; $display("FAIL skid_next: data=%h required %h", s_data, mk_data(22)); end
    valid = 1'b0;
    tick();
    n_cmp++; if (s_valid !== 1'b0) begin n_bad++; $display("FAIL skid_empty: valid=%b required 0", s_valid); end
    n_cmp++; if (s_cnt !== 16'd3) begin n_bad++; $display("FAIL skid_cnt: got %0d required 3", s_cnt); end
    n_cmp++; if (p_cnt !== 4'd3) begin n_bad++; $display("FAIL noskid_cnt: got %0d required 3", p_cnt); end
  endtask

  task automatic test_flush();
    do_reset();
    ready = 1'b0;
    drive(1'b1, 30);
    tick();
    drive(1'b1, 31);
    tick();
    n_cmp++; if (s_ready !== 1'b0) begin n_bad++; $display("FAIL flush_two_held: ready=%b required 0", s_ready); end
    flush = 1'b1; ready = 1'b1;
    drive(1'b1, 32);
    tick();
    flush = 1'b0; valid = 1'b0;
    n_cmp++; if (s_valid !== 1'b0 || s_ctrl !== '0) begin n_bad++; $display("FAIL flush_clear: valid=%b ctrl=%h required 0/0", s_valid, s_ctrl); end
    n_cmp++; if (s_data !== mk_data(30)) begin n_bad++; $display("FAIL flush_payload: data=%h required %h", s_data, mk_data(30)); end
    n_cmp++; if (s_ready !== 1'b1) begin n_bad++; $display("FAIL flush_ready: got %b required 1", s_ready); end
    ready = 1'b0;
    drive(1'b1, 33);
    tick();
    flush = 1'b1; ready = 1'b1;
    drive(1'b1, 34);
    #1;
    n_cmp++; if (s_ready !== 1'b1) begin n_bad++; $display("FAIL flush_collide_ready: got %b required 1", s_ready); end
    tick();
    flush = 1'b0; valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (s_valid !== 1'b0 || s_data !== mk_data(33)) begin n_bad++; $display("FAIL flush_dropped: cycle %0d valid=%b data=%h required 0/%h", k, s_valid, s_data, mk_data(33)); end
      tick();
    end
    drive(1'b1, 35);
    tick();
    valid = 1'b0;
    n_cmp++; if (s_valid !== 1'b1 || s_data !== mk_data(35)) begin n_bad++; $display("FAIL flush_recover: valid=%b data=%h required 1/%h", s_valid, s_data, mk_data(35)); end
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    ready = 1'b0;
    drive(1'b1, 40);
    tick();
    valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      n_cmp++; if (s_cnt !== 16'(k)) begin n_bad++; $display("FAIL sat_cnt16: cycle %0d got %0d required %0d", k, s_cnt, k); end
      n_cmp++; if (p_cnt !== 4'((k > 15) ? 15 : k)) begin n_bad++; $display("FAIL sat_cnt4: cycle %0d got %0d required %0d", k, p_cnt, (k > 15) ? 15 : k); end
    end
    ready = 1'b1;
    tick();
    n_cmp++; if (s_valid !== 1'b0 || p_cnt !== 4'd15) begin n_bad++; $display("FAIL sat_after: valid=%b cnt4=%0d required 0/15", s_valid, p_cnt); end
  endtask

  task automatic test_start_gating();
    do_reset();
    ready = 1'b0;
    drive(1'b1, 50);
    tick();
    start = 1'b0; ready = 1'b1;
    drive(1'b1, 51);
    #1;
    n_cmp++; if (s_ready !== 1'b0 || p_ready !== 1'b0) begin n_bad++; $display("FAIL gate_ready: skid=%b noskid=%b required 0/0", s_ready, p_ready); end
    tick();
    tick();
    ready = 1'b0;
    tick();
    tick();
    n_cmp++; if (s_valid !== 1'b1 || s_data !== mk_data(50) || s_ctrl !== mk_ctrl(50)) begin n_bad++; $display("FAIL gate_frozen: valid=%b data=%h ctrl=%h required 1/%h/%h", s_valid, s_data, s_ctrl, mk_data(50), mk_ctrl(50)); end
    n_cmp++; if (p_data !== mk_data(50)) begin n_bad++; $display("FAIL gate_frozen_noskid: data=%h required %h", p_data, mk_data(50)); end
    n_cmp++; if (s_cnt !== 16'd0 || p_cnt !== 4'd0) begin n_bad++; $display("FAIL gate_cnt: skid=%0d noskid=%0d required 0/0", s_cnt, p_cnt); end
    start = 1'b1; valid = 1'b0; ready = 1'b0;
    #1;
    n_cmp++; if (p_ready !== 1'b0) begin n_bad++; $display("FAIL comb_ready_low: got %b required 0", p_ready); end
    ready = 1'b1;
    #1;
    n_cmp++; if (p_ready !== 1'b1) begin n_bad++; $display("FAIL comb_ready_high: got %b required 1", p_ready); end
    tick();
    ready = 1'b0;
    drive(1'b1, 52);
    tick();
    valid = 1'b0; start = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    n_cmp++; if (s_valid !== 1'b0 || s_ctrl !== '0) begin n_bad++; $display("FAIL gate_flush: valid=%b ctrl=%h required 0/0", s_valid, s_ctrl); end
    start = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_skid_fill();
    test_flush();
    test_saturation();
    test_start_gating();
    n_cmp++;
    if (sb.size() != 0) begin n_bad++; $display("FAIL sb_leftover: %0d entries never delivered, required 0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_hs.md
# pipe_stage_hs

Parametrised handshake pipeline register that generalises the fixed-field ID/EX latch used between core stages. Each entry carries a payload bus and a control bus. Adds:
- valid/ready flow control;
- an optional skid slot that removes the combinational ready path;
- flush with bubble insertion;
- a saturating stall-cycle performance counter.

Instances sit between IF/ID, ID/EX, EX/MEM and MEM/WB. The memory-stall signal drives `stall_i` on every instance.

## Interface
- `DATA_W`, 96: payload width (register data, immediate, funct, addresses).
- `CTRL_W`, 7: control-bit width (ALUOp, ALUSrc, RegWrite, MemWrite, MemRead, MemtoReg); forced to zero on any bubble.
- `SKID`, 1: 1 = two-slot skid buffer with registered ready; 0 = single slot with pass-through ready.
- `CNT_W`, 16: stall counter width.

Ports:
- `clk_i` in 1: single clock; all state updates on the rising edge.
- `rst_i` in 1: synchronous, active-high reset.
- `start_i` in 1: global run enable; when low, no transfer on either side and no state change.
- `stall_i` in 1: downstream hold (memory stall); equivalent to `ready_i`=0.
- `flush_i` in 1: discard all held entries next edge.
- `valid_i` in 1: upstream entry valid.
- `ready_o` out 1: stage can accept.
- `data_i` in `DATA_W`: upstream payload.
- `ctrl_i` in `CTRL_W`: upstream control.
- `valid_o` out 1: output entry valid.
- `ready_i` in 1: downstream accepts.
- `data_o` out `DATA_W`: output payload.
- `ctrl_o` out `CTRL_W`: output control; all-zero whenever `valid_o`=0.
- `stall_cnt_o` out `CNT_W`: saturating count of stalled output cycles.

## Operation
- Upstream handshake: `acc_in` = `start_i` & `valid_i` & `ready_o`.
- Downstream handshake: `acc_out` = `start_i` & `valid_o` & `ready_i` & ~`stall_i`.
- SKID=1, slots: main (drives outputs) and skid.
  - `ready_o` = `start_i` & ~`skid_valid`.
  - `acc_in` with main empty, or with main draining the same cycle → entry goes to main.
  - `acc_in` with main full and not draining → entry goes to skid.
  - `acc_out` with skid full → skid moves to main, skid empties.
  - FIFO order always preserved; never more than 2 entries.
- SKID=0, single slot: `ready_o` = `start_i` & (~`valid_o` | (`ready_i` & ~`stall_i`)).
- Bubble: whenever `valid_o`=0, `ctrl_o` = 0. `data_o` holds its last loaded value (don't-care downstream).
- Flush: next edge clears both slot valids and control bits; payload registers are untouched.
  - Flush and `acc_in` in the same cycle: flush wins, incoming entry is dropped. Upstream treats it as consumed.
  - Flush and `acc_out` in the same cycle: the output transfer completes, then the slots clear.
- `start_i`=0: outputs hold; `stall_cnt_o` does not count; flush is still honoured.
- Stall counter: +1 each cycle `start_i` & `valid_o` & ~(`ready_i` & ~`stall_i`). Saturates at 2^`CNT_W`−1; never wraps. Only `rst_i` clears it.

## Timing
- Reset (edge with `rst_i`=1, overrides all other inputs): `valid_o`=0, `ctrl_o`=0, `data_o`=0, skid empty, `stall_cnt_o`=0.
  - First cycle after reset: `ready_o` = `start_i`.
- Latency: `acc_in` at edge N → `valid_o`=1 after edge N (one cycle) when main was empty or draining.
- Throughput: one entry per cycle in both modes while downstream is ready.
- SKID=1: `ready_o` falls the cycle after the skid fills. Upstream may lose at most one beat of ready, and that beat is absorbed by the skid.
- Reset asserted mid-transfer: in-flight entries are lost. No partial state survives.

## Structure
- Shared package `pipe_pkg`:
  - default widths;
  - `CTRL_BUBBLE` = '0;
  - per-stage control field offsets (ALUOp [1:0], ALUSrc, RegWrite, MemWrite, MemRead, MemtoReg), so stages share one control encoding.
- Sub-module `pipe_slot`: valid + data + ctrl register with load, clear and bubble-zeroing. Instantiated once (SKID=0) or twice (SKID=1).
- Handshake and counter logic stay in the top.

## Test plan
- Reset: hold `rst_i` 2 cycles with `valid_i`=1, `ctrl_i`=7'h7F → `valid_o`=0, `ctrl_o`=0, `data_o`=0, `stall_cnt_o`=0; after release with `start_i`=1 → `ready_o`=1.
- Streaming: SKID=1, 8 back-to-back beats (`data_i`=0..7), `ready_i`=1 → `data_o`=0..7 on consecutive cycles, starting one cycle after the first accept; `ready_o` never drops.
- Skid fill: SKID=1, `stall_i`=1 for 3 cycles during streaming → exactly one extra beat is accepted into skid and `ready_o`=0 the next cycle. After release, order is intact and `stall_cnt_o`=3.
- Flush collision: two entries held; `flush_i`=1 while `valid_i`=1 and `ready_i`=1 → `data_o` beat taken that cycle, then `valid_o`=0, `ctrl_o`=0, incoming beat never appears.
- Saturation: `CNT_W`=4, `ready_i`=0 for 20 cycles with `valid_o`=1 → `stall_cnt_o` stops at 15.
- Start gating: `start_i`=0 with `valid_i`=1 and `ready_i`=1 → `ready_o`=0, outputs frozen, counter frozen. SKID=0: `ready_o` follows `ready_i` combinationally when `start_i`=1.
